// File: rtl/graphics_pkg.sv
// Shared graphics definitions: draw FSM state encoding, glyph geometry, colour
// constants and coordinate-width helpers used by the drawers and control FSM.
package graphics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EMIT  = 2'd3
    } draw_state_t;

    localparam int   DEF_GLYPH_WIDTH  = 8;
    localparam int   DEF_GLYPH_HEIGHT = 16;
    localparam logic DEF_FG_COLOR     = 1'b1;
    localparam logic DEF_BG_COLOR     = 1'b0;

    function automatic int coord_width(input int active_pixels);
        return $clog2(active_pixels);
    endfunction

endpackage

// File: rtl/glyph_row_shifter.sv
// Holds one font row and walks it column by column, MSB (leftmost) first.
module glyph_row_shifter #(
    parameter int WIDTH = 8,
    localparam int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             advance,
    output logic             msb,
    output logic             last
);

    logic [WIDTH-1:0]     sr;
    logic [CNT_WIDTH-1:0] cnt;

    // The leftmost bit is consumed directly by the caller on load, so the
    // register always holds the bits of the columns still to come: msb is
    // the colour bit of the column after the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_data << 1;
            cnt <= '0;
        end else if (advance) begin
            sr  <= sr << 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign msb  = sr[WIDTH-1];
    assign last = (cnt == CNT_WIDTH'(WIDTH - 1));

endmodule

// File: rtl/symbol_drawer.sv
// Renders one glyph from the font ROM as a row-major stream of pixel writes,
// clipping cells that fall outside the active screen area.
module symbol_drawer
    import graphics_pkg::*;
#(
    parameter int SYMBOL_WIDTH      = 7,
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int GLYPH_WIDTH       = DEF_GLYPH_WIDTH,
    parameter int GLYPH_HEIGHT      = DEF_GLYPH_HEIGHT,
    parameter int COLOR_WIDTH       = 1,
    parameter logic [COLOR_WIDTH-1:0] FG_COLOR = COLOR_WIDTH'(DEF_FG_COLOR),
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR = COLOR_WIDTH'(DEF_BG_COLOR),
    localparam int X_WIDTH   = coord_width(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH   = coord_width(VER_ACTIVE_PIXELS),
    localparam int ROW_WIDTH = $clog2(GLYPH_HEIGHT),
    localparam int COL_WIDTH = $clog2(GLYPH_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          ready,
    input  logic [X_WIDTH-1:0]            x,
    input  logic [Y_WIDTH-1:0]            y,
    input  logic [SYMBOL_WIDTH-1:0]       symbol,
    output logic                          font_rd_en,
    output logic [SYMBOL_WIDTH+ROW_WIDTH-1:0] font_addr,
    input  logic [GLYPH_WIDTH-1:0]        font_data,
    output logic                          pixel_valid,
    input  logic                          pixel_ready,
    output logic [X_WIDTH-1:0]            pixel_x,
    output logic [Y_WIDTH-1:0]            pixel_y,
    output logic [COLOR_WIDTH-1:0]        pixel_color
);

    // Pixel handshake: a pixel transfers on a clock edge where pixel_valid and
    // pixel_ready are both high; once pixel_valid rises it, pixel_x/y and
    // pixel_color hold until that transfer, and pixel_ready may toggle freely.

    draw_state_t             state;
    logic [X_WIDTH-1:0]      x_r;
    logic [Y_WIDTH-1:0]      y_r;
    logic [SYMBOL_WIDTH-1:0] sym_r;
    logic [ROW_WIDTH-1:0]    row;
    logic [COL_WIDTH-1:0]    col;

    logic                    sh_msb;
    logic                    sh_last;
    logic [GLYPH_WIDTH-1:0]  row_bits;
    logic [COL_WIDTH-1:0]    next_col;
    logic                    next_bit;
    logic [X_WIDTH:0]        tgt_x;
    logic [Y_WIDTH:0]        tgt_y;
    logic                    on_screen;
    logic                    emit_step;

    // Symbol 0 is the blank cell regardless of what the ROM holds there.
    assign row_bits  = (sym_r == '0) ? '0 : font_data;
    assign next_col  = (state == ST_LATCH) ? '0 : col + 1'b1;
    assign next_bit  = (state == ST_LATCH) ? row_bits[GLYPH_WIDTH-1] : sh_msb;
    assign tgt_x     = {1'b0, x_r} + (X_WIDTH+1)'(next_col);
    assign tgt_y     = {1'b0, y_r} + (Y_WIDTH+1)'(row);
    assign on_screen = (tgt_x < (X_WIDTH+1)'(HOR_ACTIVE_PIXELS)) &&
                       (tgt_y < (Y_WIDTH+1)'(VER_ACTIVE_PIXELS));
    // A clipped column has pixel_valid low and retires in a single cycle.
    assign emit_step = (state == ST_EMIT) && (!pixel_valid || pixel_ready);

    glyph_row_shifter #(
        .WIDTH(GLYPH_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_LATCH),
        .load_data(row_bits),
        .advance  (emit_step),
        .msb      (sh_msb),
        .last     (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            x_r         <= '0;
            y_r         <= '0;
            sym_r       <= '0;
            row         <= '0;
            col         <= '0;
            font_rd_en  <= 1'b0;
            font_addr   <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= BG_COLOR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r        <= x;
                        y_r        <= y;
                        sym_r      <= symbol;
                        row        <= '0;
                        col        <= '0;
                        ready      <= 1'b0;
                        font_rd_en <= 1'b1;
                        font_addr  <= {symbol, ROW_WIDTH'(0)};
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    font_rd_en <= 1'b0;
                    state      <= ST_LATCH;
                end
                ST_LATCH: begin
                    col         <= next_col;
                    pixel_valid <= on_screen;
                    pixel_x     <= tgt_x[X_WIDTH-1:0];
                    pixel_y     <= tgt_y[Y_WIDTH-1:0];
                    pixel_color <= next_bit ? FG_COLOR : BG_COLOR;
                    state       <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (emit_step) begin
                        if (sh_last) begin
                            pixel_valid <= 1'b0;
                            if (row == ROW_WIDTH'(GLYPH_HEIGHT - 1)) begin
                                ready <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                row        <= row + 1'b1;
                                font_rd_en <= 1'b1;
                                font_addr  <= {sym_r, row + 1'b1};
                                state      <= ST_FETCH;
                            end
                        end else begin
                            col         <= next_col;
                            pixel_valid <= on_screen;
                            pixel_x     <= tgt_x[X_WIDTH-1:0];
                            pixel_y     <= tgt_y[Y_WIDTH-1:0];
                            pixel_color <= next_bit ? FG_COLOR : BG_COLOR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_drawer.sv
// Randomized bench for symbol_drawer: ROM model, reference pixel/read queues,
// per-cycle compare process and directed boundary scenarios.
module tb_symbol_drawer;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int SW = 7;
    localparam int AW = 11;
    localparam int GW = 8;
    localparam int GH = 16;
    localparam int PW = XW + YW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x = '0;
    logic [YW-1:0] y = '0;
    logic [SW-1:0] symbol = '0;
    logic          font_rd_en;
    logic [AW-1:0] font_addr;
    logic [GW-1:0] font_data = '0;
    logic          pixel_valid;
    logic          pixel_ready = 1'b1;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [0:0]    pixel_color;

    symbol_drawer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .x          (x),
        .y          (y),
        .symbol     (symbol),
        .font_rd_en (font_rd_en),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_color(pixel_color)
    );

    // ---------------- clock / font ROM ----------------
    always #5 clk = ~clk;

    logic [GW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) if (font_rd_en) font_data <= rom[font_addr];

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            vectors = 0;
    int            errors  = 0;
    int            pix_cnt = 0;
    int            rd_cnt  = 0;
    int            max_x   = 0;
    int            max_y   = 0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr  = '0;
    bit            rdy_rand = 1'b0;
    bit            hold = 1'b0;
    logic [PW-1:0] hold_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every in-screen cell of the glyph, row-major, plus one read per row.
    task automatic build_model(input int dx, input int dy, input int dsym);
        logic [AW-1:0] a;
        logic [GW-1:0] bits;
        int tx, ty;
        for (int r = 0; r < GH; r++) begin
            a = AW'(dsym * GH + r);
            addr_q.push_back(a);
            bits = (dsym == 0) ? '0 : rom[a];
            for (int c = 0; c < GW; c++) begin
                tx = dx + c;
                ty = dy + r;
                if (tx < 640 && ty < 480)
                    exp_q.push_back({XW'(tx), YW'(ty), bits[GW-1-c]});
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("valid_held", pixel_valid, 1'b1);
                check("pixel_stable", {pixel_x, pixel_y, pixel_color}, hold_val);
            end
            if (font_rd_en) begin
                if (addr_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL extra_font_read: got addr 0x%0h expected none", font_addr);
                end else begin
                    check("font_addr", font_addr, addr_q.pop_front());
                end
                if (rd_cnt == 0) first_addr = font_addr;
                last_addr = font_addr;
                rd_cnt++;
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) expected none", pixel_x, pixel_y);
                end else begin
                    check("pixel", {pixel_x, pixel_y, pixel_color}, exp_q.pop_front());
                end
                pix_cnt++;
                if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
                if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
            end
            hold     = pixel_valid && !pixel_ready;
            hold_val = {pixel_x, pixel_y, pixel_color};
        end
    end

    // ---------------- drivers ----------------
    initial forever begin
        @(posedge clk);
        #1;
        pixel_ready = rdy_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, ready, 1'b1);
        check({tag, "_valid"}, pixel_valid, 1'b0);
        check({tag, "_rd_en"}, font_rd_en, 1'b0);
    endtask

    task automatic draw(input int dx, input int dy, input int dsym, input int exp_pix,
                        input bit rnd, input bit inject, input int abort_at);
        int n;
        bit done;
        bit aborted;
        build_model(dx, dy, dsym);
        pix_cnt = 0; rd_cnt = 0; max_x = 0; max_y = 0;
        rdy_rand = rnd;
        @(posedge clk); #1;
        x = XW'(dx); y = YW'(dy); symbol = SW'(dsym); start = 1'b1;
        n = 0; done = 1'b0; aborted = 1'b0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (inject && n == 30) begin
                x = XW'((dx + 200) % 640); symbol = SW'(dsym ^ 7'h15); start = 1'b1;
            end
            if (abort_at > 0 && pix_cnt >= abort_at) begin
                aborted = 1'b1;
                done = 1'b1;
            end else if (ready) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            vectors++; errors++;
            $display("FAIL draw_timeout: got no ready after %0d cycles expected ready", n);
        end
        if (aborted) begin
            #2 rst_n = 1'b0;
            #1 check_idle_outputs("async_reset");
            exp_q.delete();
            addr_q.delete();
            @(posedge clk); #1;
            check_idle_outputs("reset_hold");
            @(negedge clk); #2 rst_n = 1'b1;
        end else begin
            if (!rnd) check("latency", n, 161);
            check("pixel_count", pix_cnt, exp_pix);
            check("model_drained", exp_q.size(), 0);
            check("font_reads", rd_cnt, GH);
        end
        rdy_rand = 1'b0;
    endtask

    function automatic int visible(input int dx, input int dy);
        int w, h;
        w = (dx >= 640) ? 0 : ((640 - dx) < GW ? (640 - dx) : GW);
        h = (dy >= 480) ? 0 : ((480 - dy) < GH ? (480 - dy) : GH);
        return w * h;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int rx, ry, rs;
        for (int i = 0; i < (1 << AW); i++) rom[i] = GW'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_addr", font_addr, '0);
        check("reset_xyc", {pixel_x, pixel_y, pixel_color}, '0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        draw(0, 460, 7'h41, 128, 1'b0, 1'b0, 0);
        check("first_addr", first_addr, 11'h410);
        check("last_addr", last_addr, 11'h41F);

        draw(15, 460, 0, 128, 1'b0, 1'b0, 0);
        check("blank_max_x", max_x, 22);
        check("blank_max_y", max_y, 475);

        draw(636, 470, 7'h41, 40, 1'b0, 1'b0, 0);
        check("clip_max_x", max_x, 639);
        check("clip_max_y", max_y, 479);

        draw(700, 10, 7'h22, 0, 1'b0, 1'b0, 0);

        draw(0, 460, 7'h41, 128, 1'b1, 1'b0, 0);

        draw(100, 200, 7'h42, 128, 1'b1, 1'b1, 0);

        draw(40, 40, 7'h33, 0, 1'b1, 1'b0, 50);
        check_idle_outputs("post_reset");
        draw(40, 40, 7'h33, 128, 1'b1, 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            rx = $urandom_range(0, 639);
            ry = $urandom_range(0, 479);
            rs = $urandom_range(0, 127);
            draw(rx, ry, rs, visible(rx, ry), k[0], 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        errors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/symbol_drawer.md
Name: symbol_drawer

Overview:
Renders one text glyph into the framebuffer pixel stream on a single-cycle start pulse. It is the consumer of the graphics control FSM's symbol_drawer_start/x/y and of the current symbol. It reads glyph rows from an external font ROM with 1-cycle read latency. It emits one framebuffer pixel write per glyph cell through a valid/ready handshake, shared downstream with the fill drawer.

Parameters:
SYMBOL_WIDTH, 7, symbol code width
HOR_ACTIVE_PIXELS, 640, screen width; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)
VER_ACTIVE_PIXELS, 480, screen height; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
GLYPH_WIDTH, 8, glyph columns (font row word width)
GLYPH_HEIGHT, 16, glyph rows; ROW_WIDTH = $clog2(GLYPH_HEIGHT)
COLOR_WIDTH, 1, pixel colour width
FG_COLOR, 1, colour for set font bits
BG_COLOR, 0, colour for clear font bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle draw request; sampled only when ready=1
ready  out  1  high when idle
x  in  X_WIDTH  glyph left column, sampled with start
y  in  Y_WIDTH  glyph top row, sampled with start
symbol  in  SYMBOL_WIDTH  glyph code, sampled with start
font_rd_en  out  1  font ROM read strobe
font_addr  out  SYMBOL_WIDTH+ROW_WIDTH  {symbol, row}
font_data  in  GLYPH_WIDTH  row bits, valid the cycle after font_rd_en; MSB = leftmost pixel
pixel_valid  out  1  pixel write request
pixel_ready  in  1  downstream accepts the pixel
pixel_x  out  X_WIDTH  pixel column
pixel_y  out  Y_WIDTH  pixel row
pixel_color  out  COLOR_WIDTH  FG_COLOR or BG_COLOR

Behaviour:
- Reset (async assert, sync release): state IDLE, ready=1, pixel_valid=0, font_rd_en=0, font_addr=0, pixel_x/y=0, pixel_color=BG_COLOR. Reset mid-draw abandons the glyph; no further pixels are emitted.
- All outputs are registered.
- States:
  - IDLE:
    - ready=1.
    - On start: latch x, y, symbol; row:=0, col:=0; ready:=0 on the same edge, so ready is low in the cycle after start is seen; go to FETCH.
    - start while not IDLE is ignored.
  - FETCH: font_rd_en=1 for one cycle, font_addr={symbol,row}; go to LATCH.
  - LATCH: capture font_data into the row shift register. If symbol==0, capture all zeros instead, so symbol 0 draws a blank background cell. Go to EMIT.
  - EMIT, per col:
    - Target is (x+col, y+row), computed at X_WIDTH+1 / Y_WIDTH+1 bits to detect overflow.
    - If the target is off-screen (>= HOR_ACTIVE_PIXELS or >= VER_ACTIVE_PIXELS), skip it in one cycle with no pixel_valid.
    - Otherwise present pixel_valid=1 with stable x/y/color until pixel_valid&pixel_ready, then advance.
    - pixel_color = FG_COLOR if bit (GLYPH_WIDTH-1-col) is set, else BG_COLOR.
    - After col GLYPH_WIDTH-1: if row==GLYPH_HEIGHT-1, go to IDLE (ready=1 on that edge, pixel_valid drops); else row+1, col:=0, go to FETCH.
- Latency with pixel_ready tied high and no clipping: 1 + GLYPH_HEIGHT*(2+GLYPH_WIDTH) cycles from start edge to ready high. That is 161 with defaults.
- pixel_valid never deasserts without a handshake once raised (AXI-style stability).
- Pixel order: row-major, left to right, top to bottom.

Decomposition:
- Shared package (graphics_pkg): state encodings, GLYPH_WIDTH/GLYPH_HEIGHT, colour constants, X/Y width helper functions, reused by fill drawer and control FSM.
- One natural sub-module, glyph_row_shifter: load GLYPH_WIDTH bits, shift left on advance, expose MSB and a last-column flag.

Test Plan:
- Symbol 'A' (0x41), x=0, y=460, pixel_ready=1 -> font_rd_en 16 times, addrs 0x410..0x41F; 128 pixels row-major matching ROM bits; ready high exactly 161 cycles after start.
- Symbol 0, x=15, y=460 -> 128 pixels all BG_COLOR at x 15..22, y 460..475; font reads still issued.
- x=636, y=470, symbol 0x41 -> only cols 636..639 and rows 470..479 emitted (40 pixels); no pixel with x>=640 or y>=480; ready still returns.
- pixel_ready toggling randomly 30% low -> pixel_x/y/color stable while valid&!ready; same 128-pixel sequence as the tied-high run.
- start pulsed again mid-draw with a different symbol/x -> ignored; original glyph completes unchanged.
- rst_n asserted at pixel 50 -> pixel_valid=0 and ready=1 immediately (async); next start draws a full, correct glyph.
